// File: rtl/mem_dump_reader.sv
// Streams a range of data-memory words out of the memory debug port as
// little-endian bytes over a valid/ready byte interface.
module mem_dump_reader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [31:0]       mem_check_addr,
  input  logic [31:0]       mem_check_data,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_SEND, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_cnt != CNT_ZERO) begin
            addr_d      = start_addr;
            remaining_d = word_cnt;
            state_d     = ST_RD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          shift_d    = mem_check_data;
          byte_idx_d = 2'd0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // Abort takes priority over a byte handshake in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          if (byte_idx_q != 2'd3) begin
            shift_d    = {8'h00, shift_q[31:8]};
            byte_idx_d = byte_idx_q + 2'd1;
          end else if (remaining_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - CNT_ONE;
            state_d     = ST_RD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign out_valid      = out_valid_q;
  assign out_byte       = shift_q[7:0];
  assign mem_check_addr = {{(32-ADDR_W){1'b0}}, addr_q};

endmodule
